// File: rtl/rps_pkg.sv
// Shared types for the rock-paper-scissors pipeline: move encodings,
// match FSM states, match result codes and a round well-formedness helper.
package rps_pkg;

    // One-hot move encodings used by the classifier and its upstream stages.
    typedef enum logic [2:0] {
        MOVE_ROCK     = 3'b001,
        MOVE_PAPER    = 3'b010,
        MOVE_SCISSORS = 3'b100
    } move_t;

    // Match scorer FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        DONE = 2'b10
    } match_state_t;

    // Match result as presented on match_winner.
    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_A    = 2'b01,
        WIN_B    = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    // A round is usable only if both moves were legal and exactly one of
    // the three outcome flags is raised.  Odd parity means one or three set;
    // the AND term rejects the all-three case.
    function automatic logic round_well_formed(input logic valid,
                                               input logic tie,
                                               input logic win_a,
                                               input logic win_b);
        logic exactly_one;
        exactly_one = (tie ^ win_a ^ win_b) & ~(tie & win_a & win_b);
        return valid & exactly_one;
    endfunction

endpackage

// File: rtl/rps_match_scorer_chk.sv
// Elaboration-time legality checks on the match scorer parameters.
module rps_match_scorer_chk #(
    parameter int WINS_TO_MATCH = 2,
    parameter int MAX_ROUNDS    = 9,
    parameter int SCORE_W       = 4
) ();

    if (MAX_ROUNDS > ((2 ** SCORE_W) - 1)) begin : g_bad_width
        $error("rps_match_scorer: SCORE_W too narrow to hold MAX_ROUNDS");
    end

    if ((WINS_TO_MATCH < 1) || (WINS_TO_MATCH > ((2 ** SCORE_W) - 1))) begin : g_bad_wins
        $error("rps_match_scorer: WINS_TO_MATCH out of range");
    end

    if (MAX_ROUNDS < ((2 * WINS_TO_MATCH) - 1)) begin : g_bad_cap
        $error("rps_match_scorer: MAX_ROUNDS below 2*WINS_TO_MATCH-1");
    end

endmodule

// File: rtl/rps_round_decode.sv
// Combinational decode of one classifier round into scorer increment strobes.
// Exactly one output is high when round_strobe is high, none otherwise.
module rps_round_decode
    import rps_pkg::*;
(
    input  logic round_strobe,
    input  logic valid,
    input  logic tie,
    input  logic winA,
    input  logic winB,
    output logic inc_a,
    output logic inc_b,
    output logic inc_tie,
    output logic inc_invalid
);

    logic well_formed_s;

    // Split a strobed round into win-A / win-B / tie / malformed.
    always_comb begin
        well_formed_s = round_well_formed(valid, tie, winA, winB);
        inc_a         = 1'b0;
        inc_b         = 1'b0;
        inc_tie       = 1'b0;
        inc_invalid   = 1'b0;
        if (round_strobe) begin
            if (well_formed_s) begin
                inc_a   = winA;
                inc_b   = winB;
                inc_tie = tie;
            end else begin
                inc_invalid = 1'b1;
            end
        end else begin
            inc_invalid = 1'b0;
        end
    end

endmodule

// File: rtl/rps_match_scorer.sv
// First-to-N rock-paper-scissors match scorer.  Counts rounds from the
// classifier, declares a winner or a draw at the round cap, and holds the
// result until the host acknowledges it.
module rps_match_scorer #(
    parameter int WINS_TO_MATCH = 2,
    parameter int MAX_ROUNDS    = 9,
    parameter int SCORE_W       = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               round_strobe,
    input  logic               valid,
    input  logic               tie,
    input  logic               winA,
    input  logic               winB,
    input  logic               ack,
    output logic               busy,
    output logic [SCORE_W-1:0] scoreA,
    output logic [SCORE_W-1:0] scoreB,
    output logic [SCORE_W-1:0] rounds,
    output logic [SCORE_W-1:0] invalid_cnt,
    output logic               match_done,
    output logic [1:0]         match_winner
);

    import rps_pkg::*;

    localparam logic [SCORE_W-1:0] WINS_L = SCORE_W'(WINS_TO_MATCH);
    localparam logic [SCORE_W-1:0] MAX_L  = SCORE_W'(MAX_ROUNDS);
    localparam logic [SCORE_W-1:0] ZERO_L = {SCORE_W{1'b0}};
    localparam logic [SCORE_W-1:0] ONE_L  = {{(SCORE_W-1){1'b0}}, 1'b1};
    localparam logic [SCORE_W-1:0] SAT_L  = {SCORE_W{1'b1}};

    rps_match_scorer_chk #(
        .WINS_TO_MATCH (WINS_TO_MATCH),
        .MAX_ROUNDS    (MAX_ROUNDS),
        .SCORE_W       (SCORE_W)
    ) u_chk ();

    logic inc_a_s;
    logic inc_b_s;
    logic inc_tie_s;
    logic inc_invalid_s;

    rps_round_decode u_decode (
        .round_strobe (round_strobe),
        .valid        (valid),
        .tie          (tie),
        .winA         (winA),
        .winB         (winB),
        .inc_a        (inc_a_s),
        .inc_b        (inc_b_s),
        .inc_tie      (inc_tie_s),
        .inc_invalid  (inc_invalid_s)
    );

    match_state_t       state_q,   state_d;
    winner_t            winner_q,  winner_d;
    logic [SCORE_W-1:0] score_a_q, score_a_d;
    logic [SCORE_W-1:0] score_b_q, score_b_d;
    logic [SCORE_W-1:0] rounds_q,  rounds_d;
    logic [SCORE_W-1:0] invalid_q, invalid_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;

    logic [SCORE_W-1:0] a_upd_s;
    logic [SCORE_W-1:0] b_upd_s;
    logic [SCORE_W-1:0] r_upd_s;
    logic [SCORE_W-1:0] inv_upd_s;

    // Next-state and counter update; the decision uses post-update values so
    // the deciding round is recorded on the same edge as the result.
    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        score_a_d = score_a_q;
        score_b_d = score_b_q;
        rounds_d  = rounds_q;
        invalid_d = invalid_q;

        a_upd_s = score_a_q + (inc_a_s ? ONE_L : ZERO_L);
        b_upd_s = score_b_q + (inc_b_s ? ONE_L : ZERO_L);
        r_upd_s = rounds_q + ((inc_a_s | inc_b_s | inc_tie_s) ? ONE_L : ZERO_L);
        if (inc_invalid_s && (invalid_q != SAT_L)) begin
            inv_upd_s = invalid_q + ONE_L;
        end else begin
            inv_upd_s = invalid_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = PLAY;
                    winner_d  = WIN_NONE;
                    score_a_d = ZERO_L;
                    score_b_d = ZERO_L;
                    rounds_d  = ZERO_L;
                    invalid_d = ZERO_L;
                end else begin
                    state_d = IDLE;
                end
            end
            PLAY: begin
                score_a_d = a_upd_s;
                score_b_d = b_upd_s;
                rounds_d  = r_upd_s;
                invalid_d = inv_upd_s;
                // Only a counted round can be deciding; a win on the capped
                // round is checked ahead of the draw condition.
                if (inc_a_s | inc_b_s | inc_tie_s) begin
                    if (a_upd_s == WINS_L) begin
                        state_d  = DONE;
                        winner_d = WIN_A;
                    end else if (b_upd_s == WINS_L) begin
                        state_d  = DONE;
                        winner_d = WIN_B;
                    end else if (r_upd_s == MAX_L) begin
                        state_d  = DONE;
                        winner_d = WIN_DRAW;
                    end else begin
                        state_d = PLAY;
                    end
                end else begin
                    state_d = PLAY;
                end
            end
            DONE: begin
                if (ack && start) begin
                    state_d   = PLAY;
                    winner_d  = WIN_NONE;
                    score_a_d = ZERO_L;
                    score_b_d = ZERO_L;
                    rounds_d  = ZERO_L;
                    invalid_d = ZERO_L;
                end else if (ack) begin
                    state_d  = IDLE;
                    winner_d = WIN_NONE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d   = IDLE;
                winner_d  = WIN_NONE;
                score_a_d = ZERO_L;
                score_b_d = ZERO_L;
                rounds_d  = ZERO_L;
                invalid_d = ZERO_L;
            end
        endcase

        busy_d = (state_d == PLAY);
        done_d = (state_d == DONE);
    end

    // State, counter and status registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            winner_q  <= WIN_NONE;
            score_a_q <= ZERO_L;
            score_b_q <= ZERO_L;
            rounds_q  <= ZERO_L;
            invalid_q <= ZERO_L;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            score_a_q <= score_a_d;
            score_b_q <= score_b_d;
            rounds_q  <= rounds_d;
            invalid_q <= invalid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy         = busy_q;
    assign match_done   = done_q;
    assign match_winner = winner_q;
    assign scoreA       = score_a_q;
    assign scoreB       = score_b_q;
    assign rounds       = rounds_q;
    assign invalid_cnt  = invalid_q;

endmodule

// File: tb/tb_rps_match_scorer.sv
// Directed self-checking bench for rps_match_scorer.  u_dut uses the default
// parameters (best-of-3, cap 9); u_dut1 uses WINS_TO_MATCH=1 for the
// win-on-capped-round case.  Both share all inputs.
module tb_rps_match_scorer;

    logic clk = 1'b0;
    logic rst, start, round_strobe, valid, tie, winA, winB, ack;

    logic       busy,  done;
    logic [3:0] sa, sb, rnd, inv;
    logic [1:0] win;
    logic       busy1, done1;
    logic [3:0] sa1, sb1, rnd1, inv1;
    logic [1:0] win1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rps_match_scorer u_dut (
        .clk(clk), .rst(rst), .start(start), .round_strobe(round_strobe),
        .valid(valid), .tie(tie), .winA(winA), .winB(winB), .ack(ack),
        .busy(busy), .scoreA(sa), .scoreB(sb), .rounds(rnd),
        .invalid_cnt(inv), .match_done(done), .match_winner(win)
    );

    rps_match_scorer #(.WINS_TO_MATCH(1), .MAX_ROUNDS(9), .SCORE_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .round_strobe(round_strobe),
        .valid(valid), .tie(tie), .winA(winA), .winB(winB), .ack(ack),
        .busy(busy1), .scoreA(sa1), .scoreB(sb1), .rounds(rnd1),
        .invalid_cnt(inv1), .match_done(done1), .match_winner(win1)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; drives one round for one clock and returns
    // at the next falling edge, after the DUT has registered it.
    task automatic do_round(input logic v, input logic t, input logic a, input logic b);
        round_strobe = 1'b1; valid = v; tie = t; winA = a; winB = b;
        @(negedge clk);
        round_strobe = 1'b0; valid = 1'b0; tie = 1'b0; winA = 1'b0; winB = 1'b0;
    endtask

    task automatic pulse(input logic s, input logic k);
        start = s; ack = k;
        @(negedge clk);
        start = 1'b0; ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; round_strobe = 1'b0; valid = 1'b0;
        tie = 1'b0; winA = 1'b0; winB = 1'b0; ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_winner", win, 0);
        check("rst_scoreA", sa, 0);
        check("rst_rounds", rnd, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: A, B, A -> A takes best-of-3
        pulse(1'b1, 1'b0);
        check("t1_busy_after_start", busy, 1);
        do_round(1'b1, 1'b0, 1'b1, 1'b0);
        do_round(1'b1, 1'b0, 1'b0, 1'b1);
        check("t1_not_done_yet", done, 0);
        check("t1_winner_in_play", win, 0);
        do_round(1'b1, 1'b0, 1'b1, 1'b0);
        check("t1_scoreA", sa, 2);
        check("t1_scoreB", sb, 1);
        check("t1_rounds", rnd, 3);
        check("t1_done", done, 1);
        check("t1_winner", win, 1);
        check("t1_busy", busy, 0);

        // 2: nine ties -> draw at the cap
        pulse(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) do_round(1'b1, 1'b1, 1'b0, 1'b0);
        check("t2_rounds8", rnd, 8);
        check("t2_not_done8", done, 0);
        do_round(1'b1, 1'b1, 1'b0, 1'b0);
        check("t2_rounds", rnd, 9);
        check("t2_done", done, 1);
        check("t2_winner", win, 3);
        check("t2_scoreA", sa, 0);
        check("t2_scoreB", sb, 0);

        // 3: two malformed rounds, then B, B
        pulse(1'b1, 1'b1);
        do_round(1'b0, 1'b0, 1'b1, 1'b0);
        do_round(1'b1, 1'b0, 1'b1, 1'b1);
        check("t3_inv_after_bad", inv, 2);
        check("t3_rounds_after_bad", rnd, 0);
        check("t3_scoreA_after_bad", sa, 0);
        do_round(1'b1, 1'b0, 1'b0, 1'b1);
        do_round(1'b1, 1'b0, 1'b0, 1'b1);
        check("t3_inv", inv, 2);
        check("t3_rounds", rnd, 2);
        check("t3_scoreB", sb, 2);
        check("t3_winner", win, 2);

        // 4: DONE ignores strobes and start alone; ack+start restarts
        do_round(1'b1, 1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        check("t4_hold_scoreA", sa, 0);
        check("t4_hold_scoreB", sb, 2);
        check("t4_hold_rounds", rnd, 2);
        check("t4_hold_done", done, 1);
        check("t4_hold_winner", win, 2);
        pulse(1'b1, 1'b1);
        check("t4_restart_busy", busy, 1);
        check("t4_restart_done", done, 0);
        check("t4_restart_winner", win, 0);
        check("t4_restart_scoreB", sb, 0);
        check("t4_restart_rounds", rnd, 0);
        check("t4_restart_inv", inv, 0);
        pulse(1'b0, 1'b1);
        check("t4_ack_in_play", busy, 1);

        // 5: async reset mid-match, then IDLE ignores strobes
        do_round(1'b1, 1'b0, 1'b1, 1'b0);
        do_round(1'b1, 1'b1, 1'b0, 1'b0);
        check("t5_pre_scoreA", sa, 1);
        check("t5_pre_rounds", rnd, 2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_scoreA", sa, 0);
        check("t5_async_rounds", rnd, 0);
        check("t5_async_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_round(1'b1, 1'b0, 1'b1, 1'b0);
        check("t5_idle_scoreA", sa, 0);
        check("t5_idle_rounds", rnd, 0);
        check("t5_idle_busy", busy, 0);
        pulse(1'b0, 1'b1);
        check("t5_idle_ack_done", done, 0);

        // 6: eight ties then A on round nine
        pulse(1'b1, 1'b0);
        check("t6_busy1", busy1, 1);
        for (int i = 0; i < 8; i++) do_round(1'b1, 1'b1, 1'b0, 1'b0);
        check("t6_not_done8", done1, 0);
        check("t6_rounds8", rnd1, 8);
        do_round(1'b1, 1'b0, 1'b1, 1'b0);
        check("t6_winner1", win1, 1);
        check("t6_rounds1", rnd1, 9);
        check("t6_scoreA1", sa1, 1);
        check("t6_scoreB1", sb1, 0);
        check("t6_inv1", inv1, 0);
        check("t6_done1", done1, 1);
        // Same rounds on best-of-3: only one win, so the cap makes it a draw.
        check("t6_cap_draw", win, 3);
        check("t6_cap_scoreA", sa, 1);

        // Saturation of the rejected-round counter
        pulse(1'b1, 1'b1);
        for (int i = 0; i < 17; i++) do_round(1'b0, 1'b0, 1'b0, 1'b0);
        check("sat_inv", inv, 15);
        check("sat_rounds", rnd, 0);
        check("sat_busy", busy, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
